// File: rtl/s27_state_seq_if.sv
// Frame stream bundle for s27_state_seq: input vector handshake and result handshake.
interface s27_state_seq_if #(
  parameter int FRAME_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_vec;
  logic               out_valid;
  logic               out_ready;
  logic               out_g17;
  logic [FRAME_W-1:0] out_frame;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_g17, out_frame
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_g17, out_frame
  );
endinterface

// File: rtl/s27_state_seq.sv
// Sequential wrapper around the combinational s27 core: owns the state flops, frames one vector at a time.
// Optional MISR signature output enabled by defining S27_SIG_EN.
module s27_state_seq #(
  parameter int         FRAME_W   = 8,
  parameter logic [2:0] RST_STATE = 3'b000
) (
  input  logic CK,
  input  logic RN,
  s27_state_seq_if.slave bus,
  output logic G0,
  output logic G1,
  output logic G2,
  output logic G3,
  output logic DFF_0_Q,
  output logic DFF_1_Q,
  output logic DFF_2_Q,
  input  logic DFF_0_D,
  input  logic DFF_1_D,
  input  logic DFF_2_D,
  input  logic G17,
  input  logic scan_en,
  input  logic scan_in,
  output logic scan_out
`ifdef S27_SIG_EN
  ,
  output logic [15:0] sig
`endif
);

  typedef enum logic [1:0] {IDLE, APPLY, HOLD, SCAN} state_t;

  localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_nextState;
  logic               w_inReady;
  logic               w_accept;
  logic               w_apply;
  logic               w_shift;
  logic [3:0]         r_g;
  logic [2:0]         r_q;
  logic               r_outValid;
  logic               r_outG17;
  logic [FRAME_W-1:0] r_outFrame;
  logic [FRAME_W-1:0] r_frameCnt;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Scan wins over a new vector in IDLE; scan_en is ignored while a frame is in flight.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = !scan_en;
        if (scan_en)           w_nextState = SCAN;
        else if (bus.in_valid) w_nextState = APPLY;
      end
      APPLY: w_nextState = HOLD;
      HOLD: begin
        w_inReady = bus.out_ready;
        if (bus.out_ready) w_nextState = bus.in_valid ? APPLY : IDLE;
      end
      SCAN: begin
        if (!scan_en) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_accept = bus.in_valid && w_inReady;
  assign w_apply  = (r_state == APPLY);
  // The edge that enters SCAN already shifts, so N cycles of scan_en move N bits.
  assign w_shift  = scan_en && ((r_state == IDLE) || (r_state == SCAN));

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_g        <= 4'b0000;
      r_q        <= RST_STATE;
      r_outValid <= 1'b0;
      r_outG17   <= 1'b0;
      r_outFrame <= '0;
      r_frameCnt <= '0;
    end else begin
      if (w_accept) r_g <= bus.in_vec;
      if (w_apply) begin
        r_q        <= {DFF_2_D, DFF_1_D, DFF_0_D};
        r_outG17   <= G17;
        r_outFrame <= r_frameCnt;
        r_frameCnt <= r_frameCnt + FRAME_ONE;
        r_outValid <= 1'b1;
      end else if (w_shift) begin
        r_q <= {r_q[1:0], scan_in};
      end
      if ((r_state == HOLD) && bus.out_ready) r_outValid <= 1'b0;
    end
  end

`ifdef S27_SIG_EN
  logic [15:0] r_sig;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_sig <= 16'hFFFF;
    end else if (w_apply) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000) ^
               {12'b0, G17, DFF_2_D, DFF_1_D, DFF_0_D};
    end
  end

  assign sig = r_sig;
`endif

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_g17   = r_outG17;
  assign bus.out_frame = r_outFrame;

  assign {G3, G2, G1, G0}          = r_g;
  assign {DFF_2_Q, DFF_1_Q, DFF_0_Q} = r_q;
  assign scan_out                  = r_q[2];

endmodule
